// File: rtl/gsplat_tile_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : gsplat_tile_dispatcher
// Description : Walks a packed tile list in DDR3 and feeds gsplat_core one
//               tile at a time. It reads each 2-qword tile header, derives
//               px/py/splat_count and the address of the next header, and
//               pulses tile_start. The next header is prefetched while the
//               core rasterizes the current tile.
// Options     : GSPLAT_DISPATCH_PERF_EN adds the perf_stall_cycles and
//               perf_fetch_wait counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module gsplat_tile_dispatcher #(
  parameter int HDR_BURST    = 2,
  parameter int SPLAT_QWORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [28:0] list_base,
  input  logic [15:0] tile_count,
  input  logic [28:0] fb_base_in,
  output logic        done,
  output logic        busy,
  output logic [28:0] rd_addr,
  output logic [7:0]  rd_burstcnt,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [63:0] rd_data,
  input  logic        rd_data_valid,
  output logic        tile_start,
  output logic [28:0] tile_addr,
  output logic [15:0] tile_px,
  output logic [15:0] tile_py,
  output logic [31:0] tile_splat_count,
  output logic [28:0] fb_base,
`ifdef GSPLAT_DISPATCH_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_fetch_wait,
`endif
  input  logic        tile_done,
  input  logic        core_busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FETCH_REQ  = 3'd1;
  localparam logic [2:0] S_FETCH_DATA = 3'd2;
  localparam logic [2:0] S_DISPATCH   = 3'd3;
  localparam logic [2:0] S_WAIT_LAST  = 3'd4;
  localparam logic [2:0] S_FINISH     = 3'd5;

  localparam logic [7:0] C_BURST     = 8'(HDR_BURST);
  localparam logic [7:0] C_LAST_BEAT = 8'(HDR_BURST - 1);

  logic [2:0]  r_state, w_next_state;
  logic [28:0] r_fetch_addr;
  logic [15:0] r_fetch_left, r_disp_left;
  logic [7:0]  r_beat;
  logic        r_buf_valid;
  logic [28:0] r_buf_addr;
  logic [15:0] r_buf_px, r_buf_py;
  logic [31:0] r_buf_count;
  logic        r_outstanding;
  logic        r_tile_start;
  logic [28:0] r_tile_addr;
  logic [15:0] r_tile_px, r_tile_py;
  logic [31:0] r_tile_count;
  logic [28:0] r_fb_base;
  logic        r_done;

  logic        w_start_ok;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_dispatch;
  logic        w_busy;
  logic [31:0] w_hdr_count;
  logic [28:0] w_next_addr;

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_beat      = (r_state == S_FETCH_DATA) && rd_data_valid;
  assign w_last_beat = w_beat && (r_beat == C_LAST_BEAT);
  assign w_dispatch  = (r_state == S_DISPATCH) && r_buf_valid && !core_busy && !r_outstanding;
  // With a single-beat header the count is still on the bus when the address advances.
  assign w_hdr_count = (r_beat == 8'd0) ? rd_data[63:32] : r_buf_count;
  // Splats are stored inline after the header, so the next header follows them.
  assign w_next_addr = r_fetch_addr + 29'(HDR_BURST) + 29'(w_hdr_count * 32'(SPLAT_QWORDS));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic for the list walk.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next_state = (tile_count == 16'd0) ? S_FINISH : S_FETCH_REQ;
      S_FETCH_REQ:  if (rd_ack) w_next_state = S_FETCH_DATA;
      S_FETCH_DATA: if (w_last_beat) w_next_state = S_DISPATCH;
      S_DISPATCH:   if (w_dispatch) w_next_state = (r_fetch_left != 16'd0) ? S_FETCH_REQ : S_WAIT_LAST;
      S_WAIT_LAST:  if (tile_done && r_outstanding && (r_disp_left == 16'd0)) w_next_state = S_FINISH;
      S_FINISH:     w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Output decode: read request is held for the whole FETCH_REQ state.
  always_comb begin
    rd_req      = (r_state == S_FETCH_REQ);
    rd_addr     = (r_state == S_FETCH_REQ) ? r_fetch_addr : 29'd0;
    rd_burstcnt = (r_state == S_FETCH_REQ) ? C_BURST : 8'd0;
    w_busy      = (r_state == S_FETCH_REQ) || (r_state == S_FETCH_DATA) ||
                  (r_state == S_DISPATCH)  || (r_state == S_WAIT_LAST);
    busy             = w_busy;
    done             = r_done;
    tile_start       = r_tile_start;
    tile_addr        = r_tile_addr;
    tile_px          = r_tile_px;
    tile_py          = r_tile_py;
    tile_splat_count = r_tile_count;
    fb_base          = r_fb_base;
  end

  // Walk datapath: fetch pointer, header buffer, dispatched tile and handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_addr  <= '0;
      r_fetch_left  <= '0;
      r_disp_left   <= '0;
      r_beat        <= '0;
      r_buf_valid   <= 1'b0;
      r_buf_addr    <= '0;
      r_buf_px      <= '0;
      r_buf_py      <= '0;
      r_buf_count   <= '0;
      r_outstanding <= 1'b0;
      r_tile_start  <= 1'b0;
      r_tile_addr   <= '0;
      r_tile_px     <= '0;
      r_tile_py     <= '0;
      r_tile_count  <= '0;
      r_fb_base     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done       <= (r_state == S_FINISH);
      r_tile_start <= w_dispatch;
      if (w_start_ok) begin
        r_fb_base    <= fb_base_in;
        r_fetch_addr <= list_base;
        r_fetch_left <= tile_count;
        r_disp_left  <= tile_count;
        r_beat       <= '0;
        r_buf_valid  <= 1'b0;
      end
      if (w_beat) begin
        if (r_beat == 8'd0) begin
          r_buf_addr  <= r_fetch_addr;
          r_buf_px    <= rd_data[15:0];
          r_buf_py    <= rd_data[31:16];
          r_buf_count <= rd_data[63:32];
          r_buf_valid <= 1'b1;
        end
        if (w_last_beat) begin
          r_beat       <= '0;
          r_fetch_addr <= w_next_addr;
          r_fetch_left <= r_fetch_left - 16'd1;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
      if (w_dispatch) begin
        r_tile_addr  <= r_buf_addr;
        r_tile_px    <= r_buf_px;
        r_tile_py    <= r_buf_py;
        r_tile_count <= r_buf_count;
        r_buf_valid  <= 1'b0;
        r_disp_left  <= r_disp_left - 16'd1;
      end
      // A dispatch in the same cycle as tile_done keeps the new tile outstanding.
      if (w_dispatch)     r_outstanding <= 1'b1;
      else if (tile_done) r_outstanding <= 1'b0;
    end
  end

`ifdef GSPLAT_DISPATCH_PERF_EN
  logic [31:0] r_perf_stall, r_perf_wait;

  // Saturating stall / fetch-wait counters, cleared on every accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_wait  <= '0;
    end else if (w_start_ok) begin
      r_perf_stall <= '0;
      r_perf_wait  <= '0;
    end else begin
      if ((r_state == S_DISPATCH) && r_buf_valid && (core_busy || r_outstanding) &&
          (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_busy && !core_busy && !r_buf_valid && (r_perf_wait != 32'hFFFF_FFFF))
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_fetch_wait   = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gsplat_tile_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gsplat_tile_dispatcher
// Description : Self-checking bench for gsplat_tile_dispatcher with a DDR3
//               responder, a core model and an arithmetic list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gsplat_tile_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [28:0] list_base = '0;
  logic [15:0] tile_count = '0;
  logic [28:0] fb_base_in = '0;
  logic        done, busy, rd_req, tile_start;
  logic [28:0] rd_addr, tile_addr, fb_base;
  logic [7:0]  rd_burstcnt;
  logic        rd_ack = 1'b0;
  logic [63:0] rd_data = '0;
  logic        rd_data_valid = 1'b0;
  logic [15:0] tile_px, tile_py;
  logic [31:0] tile_splat_count;
  logic        tile_done = 1'b0;
  logic        core_busy = 1'b0;
`ifdef GSPLAT_DISPATCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_fetch_wait;
`endif

  gsplat_tile_dispatcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .list_base(list_base),
    .tile_count(tile_count), .fb_base_in(fb_base_in), .done(done), .busy(busy),
    .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .tile_start(tile_start),
    .tile_addr(tile_addr), .tile_px(tile_px), .tile_py(tile_py),
    .tile_splat_count(tile_splat_count), .fb_base(fb_base),
`ifdef GSPLAT_DISPATCH_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_fetch_wait(perf_fetch_wait),
`endif
    .tile_done(tile_done), .core_busy(core_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Test knobs (written only by the main sequence).
  int ack_dly = 0, beat_dly = 0, work_fix = 20, hold_tile = -1, hold_len = 0, stray_req = 0;
  logic [63:0] mem [int unsigned];
  logic [28:0] exp_addr[$];
  logic [63:0] exp_hdr[$];

  // Observations (each written by exactly one process).
  logic [28:0] rd_log[$];
  logic [7:0]  bc_log[$];
  int hold_err = 0, stray_done = 0;
  logic [28:0] ts_addr[$];
  logic [63:0] ts_hdr[$];
  int ts_cyc[$];
  int done_cnt = 0, done_cyc = 0;
  int core_n = 0, hold_drop_cyc = 0, hold_reads = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // DDR3 responder: ack after a delay, then header beat and a junk beat.
  always begin : p_mem
    logic [28:0] a;
    int d;
    @(negedge clk);
    if (reset_n && rd_req) begin
      a = rd_addr;
      rd_log.push_back(a);
      bc_log.push_back(rd_burstcnt);
      d = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
      repeat (d) begin
        @(negedge clk);
        if (reset_n && (!rd_req || rd_addr != a)) hold_err++;
      end
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      d = (beat_dly < 0) ? int'($urandom_range(0, 3)) : beat_dly;
      repeat (d) @(negedge clk);
      rd_data = mem.exists(a) ? mem[a] : 64'hDEAD_BEEF_0BAD_F00D;
      rd_data_valid = 1'b1;
      @(negedge clk);
      rd_data = {$urandom, $urandom};
      @(negedge clk);
      rd_data_valid = 1'b0;
      rd_data = '0;
    end else if (stray_req != stray_done) begin
      rd_data = {$urandom, $urandom};
      rd_data_valid = 1'b1;
      @(negedge clk);
      rd_data_valid = 1'b0;
      stray_done++;
    end
  end

  // Core model: busy for a work period, tile_done pulse, optional extra busy hold.
  always begin : p_core
    int w, h;
    @(negedge clk);
    if (tile_start) begin
      core_busy = 1'b1;
      w = (work_fix < 0) ? int'($urandom_range(1, 30)) : work_fix;
      repeat (w) @(negedge clk);
      tile_done = 1'b1;
      h = (core_n == hold_tile) ? hold_len : 0;
      core_n++;
      @(negedge clk);
      tile_done = 1'b0;
      repeat (h) @(negedge clk);
      core_busy = 1'b0;
      if (h > 0) begin
        hold_drop_cyc = cyc;
        hold_reads = rd_log.size();
      end
    end
  end

  // Output monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (tile_start) begin
      ts_addr.push_back(tile_addr);
      ts_hdr.push_back({tile_splat_count, tile_py, tile_px});
      ts_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference list: header i+1 sits after header i's 2 qwords plus 4 qwords per splat.
  task automatic build_list(input logic [28:0] base, input int n, input bit fixed);
    logic [28:0] a;
    logic [31:0] cnt;
    logic [63:0] h;
    exp_addr.delete();
    exp_hdr.delete();
    a = base;
    for (int i = 0; i < n; i++) begin
      cnt = fixed ? ((i == 0) ? 32'd2 : (i == 1) ? 32'd0 : 32'd5) : $urandom_range(0, 15);
      h = {cnt, 16'($urandom), 16'($urandom)};
      mem[a] = h;
      exp_addr.push_back(a);
      exp_hdr.push_back(h);
      a = a + 29'd2 + 29'(cnt * 4);
    end
  endtask

  int r0, t0;

  task automatic run_walk(input string tag, input logic [28:0] base, input int n, input logic [28:0] fb);
    int d0, st;
    r0 = rd_log.size();
    t0 = ts_addr.size();
    d0 = done_cnt;
    @(negedge clk);
    list_base = base; tile_count = 16'(n); fb_base_in = fb; start = 1'b1; st = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy1"}, busy, n > 0);
    chk({tag, "_req1"}, rd_req, n > 0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_fb"}, fb_base, fb);
    chk({tag, "_nreads"}, rd_log.size() - r0, n);
    chk({tag, "_nstarts"}, ts_addr.size() - t0, n);
    if (n == 0) chk({tag, "_done_lat"}, done_cyc - st, 2);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_rd%0d", tag, i), (r0 + i < rd_log.size()) ? rd_log[r0 + i] : 29'bx, exp_addr[i]);
      chk($sformatf("%s_bc%0d", tag, i), (r0 + i < bc_log.size()) ? bc_log[r0 + i] : 8'bx, 8'd2);
      chk($sformatf("%s_ta%0d", tag, i), (t0 + i < ts_addr.size()) ? ts_addr[t0 + i] : 29'bx, exp_addr[i]);
      chk($sformatf("%s_hdr%0d", tag, i), (t0 + i < ts_hdr.size()) ? ts_hdr[t0 + i] : 64'bx, exp_hdr[i]);
    end
  endtask

  initial begin
    int he, base_ts;
    logic [28:0] b;
    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_outs", |{done, busy, rd_addr, rd_burstcnt, rd_req, tile_start, tile_addr,
                      tile_px, tile_py, tile_splat_count, fb_base}, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1) three tiles with counts 2,0,5, 20-cycle core.
    build_list(29'h1000, 3, 1'b1);
    run_walk("t1", 29'h1000, 3, 29'h0ABCDE);
    chk("t1_addr0", rd_log[r0], 29'h1000);
    chk("t1_addr1", rd_log[r0 + 1], 29'h100A);
    chk("t1_addr2", rd_log[r0 + 2], 29'h100C);

    // 3) core_busy held 100 cycles after tile 0.
    build_list(29'h0200_0000, 3, 1'b0);
    hold_tile = core_n; hold_len = 100;
    run_walk("t3", 29'h0200_0000, 3, 29'h1234);
    hold_tile = -1;
    chk("t3_prefetch", hold_reads - r0, 2);
    chk("t3_start_lat", ((t0 + 1 < ts_cyc.size()) ? ts_cyc[t0 + 1] : 0) - hold_drop_cyc, 1);
`ifdef GSPLAT_DISPATCH_PERF_EN
    chk("t6_stall_ge99", perf_stall_cycles >= 32'd99, 1'b1);
`endif

    // 2) empty list: no reads, no tiles, done two cycles after start.
    run_walk("t2", 29'h0777, 0, 29'h55);
`ifdef GSPLAT_DISPATCH_PERF_EN
    chk("t6_stall_clr", perf_stall_cycles, 0);
    chk("t6_wait_clr", perf_fetch_wait, 0);
`endif

    // 4) stray beat in IDLE, then a 10-cycle ack delay.
    base_ts = ts_addr.size();
    stray_req++;
    repeat (6) @(negedge clk);
    chk("t4_stray_busy", busy, 0);
    chk("t4_stray_start", ts_addr.size() - base_ts, 0);
    he = hold_err;
    ack_dly = 10;
    build_list(29'h0003_0040, 2, 1'b0);
    run_walk("t4", 29'h0003_0040, 2, 29'h99);
    chk("t4_req_held", hold_err - he, 0);
    ack_dly = 0;

    // 5) reset during FETCH_DATA, then a clean walk.
    beat_dly = 3;
    build_list(29'h0004_0000, 3, 1'b0);
    @(negedge clk);
    list_base = 29'h0004_0000; tile_count = 16'd3; fb_base_in = 29'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (rd_ack) break;
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_outs", |{done, busy, rd_addr, rd_burstcnt, rd_req, tile_start, tile_addr,
                         tile_px, tile_py, tile_splat_count, fb_base}, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    base_ts = ts_addr.size();
    repeat (8) @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_no_start", ts_addr.size() - base_ts, 0);
    beat_dly = 0;
    run_walk("t5", 29'h0004_0000, 3, 29'h78);

    // Randomized lists with random memory and core timing, one wrapping past 2^29.
    ack_dly = -1; beat_dly = -1; work_fix = -1;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 29'h1FFF_FFF0 : 29'($urandom);
      he = int'($urandom_range(1, 5));
      build_list(b, he, 1'b0);
      run_walk($sformatf("rnd%0d", k), b, he, 29'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
